// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, CTRL bit positions and widths for peripheral_timer
package timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4
    } reg_offset_e;

    localparam int CTRL_W          = 3;
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int STATUS_MATCH    = 0;
    localparam int PRESCALE_W      = 16;
    localparam int COUNT_W         = 32;

    function automatic logic [31:0] apply_wmask(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wmask);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides clk by prescale+1, one-cycle tick while enabled
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic                  tick_q;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            presc_cnt <= '0;
            tick_q    <= 1'b0;
        end else if (presc_cnt == prescale) begin
            presc_cnt <= '0;
            tick_q    <= 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
            tick_q    <= 1'b0;
        end
    end

    // A tick registered just before EN drops must not reach the counter.
    assign tick = tick_q && en;

endmodule

// File: rtl/peripheral_timer.sv
// rtl/peripheral_timer.sv - bus-mapped 32-bit timer with prescaler, compare match and irq
module peripheral_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] ADDRESS_BASE = 32'h07000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_wstrb,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        select,
    output logic        irq
);

    logic [CTRL_W-1:0]     ctrl,     ctrl_next;
    logic [PRESCALE_W-1:0] prescale, prescale_next;
    logic [COUNT_W-1:0]    count,    count_next;
    logic [COUNT_W-1:0]    compare,  compare_next;
    logic                  match,    match_next;
    logic [31:0]           rdata_next;
    logic                  tick;
    logic [2:0]            offset;
    logic                  wr, rd, count_wr, match_set, match_clr;
    logic                  unused_addr_bits;

    assign select   = (mem_addr[31:24] == ADDRESS_BASE[31:24]);
    assign mem_done = select && (mem_rstrb || mem_wstrb);
    assign offset   = mem_addr[4:2];
    assign wr       = select && mem_wstrb;
    assign rd       = select && mem_rstrb;
    assign unused_addr_bits = ^{mem_addr[23:5], mem_addr[1:0]};

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl[CTRL_EN]),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        ctrl_next     = ctrl;
        prescale_next = prescale;
        compare_next  = compare;
        count_next    = count;
        count_wr      = wr && (offset == REG_COUNT) && (|mem_wmask);
        match_set     = 1'b0;
        match_clr     = wr && (offset == REG_STATUS) && mem_wmask[0] && mem_wdata[STATUS_MATCH];

        if (wr && (offset == REG_CTRL) && mem_wmask[0])
            ctrl_next = mem_wdata[CTRL_W-1:0];
        if (wr && (offset == REG_PRESCALE)) begin
            for (int b = 0; b < 2; b++) begin
                if (mem_wmask[b]) prescale_next[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
        if (wr && (offset == REG_COMPARE))
            compare_next = apply_wmask(compare, mem_wdata, mem_wmask);

        // Software write to COUNT beats the tick entirely, including its match check.
        if (count_wr) begin
            count_next = apply_wmask(count, mem_wdata, mem_wmask);
        end else if (tick) begin
            if (count == compare) begin
                match_set  = 1'b1;
                count_next = ctrl[CTRL_AUTORELOAD] ? '0 : count + 1'b1;
            end else begin
                count_next = count + 1'b1;
            end
        end

        match_next = match_set || (match && !match_clr);

        rdata_next = mem_rdata;
        if (rd) begin
            case (offset)
                REG_CTRL:     rdata_next = {{(32-CTRL_W){1'b0}}, ctrl};
                REG_PRESCALE: rdata_next = {{(32-PRESCALE_W){1'b0}}, prescale};
                REG_COUNT:    rdata_next = count;
                REG_COMPARE:  rdata_next = compare;
                REG_STATUS:   rdata_next = {31'b0, match};
                default:      rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            prescale  <= '0;
            count     <= '0;
            compare   <= '0;
            match     <= 1'b0;
            mem_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            ctrl      <= ctrl_next;
            prescale  <= prescale_next;
            count     <= count_next;
            compare   <= compare_next;
            match     <= match_next;
            mem_rdata <= rdata_next;
            irq       <= match_next && ctrl_next[CTRL_IRQEN];
        end
    end

endmodule

// File: tb/tb_peripheral_timer.sv
// tb/tb_peripheral_timer.sv - self-checking bench for peripheral_timer
module tb_peripheral_timer;

    localparam logic [31:0] BASE = 32'h07000000;
    localparam int O_CTRL = 0, O_PRESC = 1, O_COUNT = 2, O_CMP = 3, O_STATUS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_wstrb = 1'b0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        select;
    logic        irq;

    int compared = 0;
    int mismatched = 0;

    peripheral_timer #(.ADDRESS_BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_wstrb (mem_wstrb),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .select    (select),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] data, input logic [3:0] mask);
        mem_addr  = BASE | (32'(off) << 2);
        mem_wdata = data;
        mem_wmask = mask;
        mem_wstrb = 1'b1;
        cyc();
        mem_wstrb = 1'b0;
        mem_wmask = '0;
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        mem_addr  = BASE | (32'(off) << 2);
        mem_rstrb = 1'b1;
        cyc();
        mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    // Ticks that have reached COUNT j edges after the edge that set EN.
    function automatic int ticks_after(input int j, input int p);
        return (j == 0) ? 0 : (j - 1) / (p + 1);
    endfunction

    task automatic model(input int nt, input logic [31:0] c0, input logic [31:0] cmp,
                         input bit ar, output logic [31:0] c, output bit m);
        c = c0;
        m = 1'b0;
        for (int i = 0; i < nt; i++) begin
            if (c == cmp) begin
                m = 1'b1;
                c = ar ? 32'd0 : c + 32'd1;
            end else begin
                c = c + 32'd1;
            end
        end
    endtask

    initial begin
        logic [31:0] d, ec;
        logic [31:0] seq32 [7];
        logic [31:0] seqw [5];
        bit em;
        int p, w, c0, cmp, ar, ie;

        seq32 = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        seqw  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1};

        // reset state
        @(negedge clk);
        cyc();
        reset = 1'b0;
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_select", {31'b0, select}, 32'd0);
        check("rst_done", {31'b0, mem_done}, 32'd0);
        for (int o = 0; o < 5; o++) begin
            rd(o, d);
            check($sformatf("rst_reg%0d", o), d, 32'd0);
        end

        // PRESCALE=0 COMPARE=3 autoreload: 0,1,2,3,0,1
        do_reset();
        wr(O_CMP, 32'd3, 4'hF);
        wr(O_CTRL, 32'd3, 4'hF);
        for (int j = 1; j <= 7; j++) begin
            rd(O_COUNT, d);
            check($sformatf("seq_count%0d", j), d, seq32[j-1]);
        end
        rd(O_STATUS, d);
        check("seq_match", d, 32'd1);

        // PRESCALE=4 COMPARE=2 CTRL=7: irq 16 cycles after enable, W1C drops it
        do_reset();
        wr(O_PRESC, 32'd4, 4'hF);
        wr(O_CMP, 32'd2, 4'hF);
        wr(O_CTRL, 32'd7, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check($sformatf("irq_k%0d", k), {31'b0, irq}, (k == 16) ? 32'd1 : 32'd0);
        end
        wr(O_STATUS, 32'd1, 4'h1);
        check("irq_w1c", {31'b0, irq}, 32'd0);

        // wrap without match
        do_reset();
        wr(O_COUNT, 32'hFFFFFFFE, 4'hF);
        wr(O_CMP, 32'd5, 4'hF);
        wr(O_CTRL, 32'd1, 4'hF);
        for (int j = 1; j <= 5; j++) begin
            rd(O_COUNT, d);
            check($sformatf("wrap_count%0d", j), d, seqw[j-1]);
        end
        rd(O_STATUS, d);
        check("wrap_match", d, 32'd0);

        // COUNT write coincident with a matching tick wins
        do_reset();
        wr(O_CMP, 32'd2, 4'hF);
        wr(O_CTRL, 32'd1, 4'hF);
        idle(3);
        wr(O_COUNT, 32'd100, 4'hF);
        rd(O_COUNT, d);
        check("cwr_count", d, 32'd100);
        rd(O_STATUS, d);
        check("cwr_match", d, 32'd0);

        // W1C coincident with a match set keeps MATCH
        do_reset();
        wr(O_CTRL, 32'd3, 4'hF);
        idle(2);
        wr(O_STATUS, 32'd1, 4'h1);
        rd(O_STATUS, d);
        check("w1c_vs_set", d, 32'd1);

        // byte masks, reserved offsets, decode and done
        do_reset();
        wr(O_CMP, 32'hAABBCCDD, 4'b0010);
        mem_addr  = BASE | (32'(O_CMP) << 2);
        mem_rstrb = 1'b1;
        #1;
        check("done_comb", {31'b0, mem_done}, 32'd1);
        check("select_hit", {31'b0, select}, 32'd1);
        check("rdata_prior", mem_rdata, 32'd0);
        cyc();
        mem_rstrb = 1'b0;
        check("cmp_bytemask", mem_rdata, 32'h0000CC00);
        mem_addr  = 32'h08000000 | (32'(O_CTRL) << 2);
        mem_rstrb = 1'b1;
        #1;
        check("select_miss", {31'b0, select}, 32'd0);
        check("done_miss", {31'b0, mem_done}, 32'd0);
        cyc();
        mem_rstrb = 1'b0;
        check("rdata_hold", mem_rdata, 32'h0000CC00);
        wr(6, 32'hFFFFFFFF, 4'hF);
        rd(6, d);
        check("off6_zero", d, 32'd0);
        wr(O_CTRL, 32'hFFFFFFF0, 4'hF);
        rd(O_CTRL, d);
        check("ctrl_reserved", d, 32'd0);
        wr(O_PRESC, 32'hFFFFFFFF, 4'hF);
        rd(O_PRESC, d);
        check("presc_width", d, 32'h0000FFFF);

        // reset mid-count with irq high
        do_reset();
        wr(O_CMP, 32'd3, 4'hF);
        wr(O_CTRL, 32'd5, 4'hF);
        idle(8);
        check("mid_irq", {31'b0, irq}, 32'd1);
        rd(O_COMPARE_SAFE(), d);
        check("mid_cmp", d, 32'd3);
        do_reset();
        check("mid_rst_irq", {31'b0, irq}, 32'd0);
        check("mid_rst_rdata", mem_rdata, 32'd0);
        for (int o = 0; o < 5; o++) begin
            rd(o, d);
            check($sformatf("mid_rst_reg%0d", o), d, 32'd0);
        end
        idle(3);
        rd(O_COUNT, d);
        check("mid_idle_count", d, 32'd0);
        wr(O_CTRL, 32'd1, 4'hF);
        idle(3);
        rd(O_COUNT, d);
        check("mid_resume", d, 32'd2);

        // randomized trials against the tick-level model
        for (int t = 0; t < 20; t++) begin
            p   = $urandom_range(0, 5);
            c0  = $urandom_range(0, 6);
            cmp = $urandom_range(0, 8);
            ar  = $urandom_range(0, 1);
            ie  = $urandom_range(0, 1);
            w   = $urandom_range(0, 30);
            do_reset();
            wr(O_PRESC, 32'(p), 4'hF);
            wr(O_CMP, 32'(cmp), 4'hF);
            wr(O_COUNT, 32'(c0), 4'hF);
            wr(O_CTRL, {29'b0, ie[0], ar[0], 1'b1}, 4'hF);
            idle(w);
            rd(O_COUNT, d);
            model(ticks_after(w, p), 32'(c0), 32'(cmp), ar[0], ec, em);
            check($sformatf("rand%0d_count", t), d, ec);
            model(ticks_after(w + 1, p), 32'(c0), 32'(cmp), ar[0], ec, em);
            check($sformatf("rand%0d_irq", t), {31'b0, irq}, {31'b0, em & ie[0]});
            rd(O_STATUS, d);
            check($sformatf("rand%0d_match", t), d, {31'b0, em});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    function automatic int O_COMPARE_SAFE();
        return O_CMP;
    endfunction

endmodule
